// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D memory arbiter (line/word types, FSM states, grant source).
// The optional LC3B_ARB_RR_EN macro selects round-robin instead of D-priority picking.
package mem_arbiter_pkg;

  localparam int LC3B_ADDR_W = 16;
  localparam int LC3B_LINE_W = 128;
  localparam int STREAK_W    = 4;

  typedef logic [LC3B_ADDR_W-1:0] lc3b_word;
  typedef logic [LC3B_LINE_W-1:0] lc3b_line;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY_I,
    ARB_BUSY_D,
    ARB_RELEASE
  } lc3b_arb_state;

  typedef enum logic {
    ARB_SRC_I,
    ARB_SRC_D
  } lc3b_arb_src;

  // Consecutive-D counter: only D grants that overtake a waiting fetch count.
  function automatic logic [STREAK_W-1:0] streak_next(
    input logic [STREAK_W-1:0] cur,
    input logic                grant_d,
    input logic                i_pending,
    input logic [STREAK_W-1:0] max_streak
  );
    if (!grant_d) return '0;
    if (i_pending && (cur != max_streak)) return cur + 1'b1;
    return cur;
  endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational grant selection between I and D requesters.
// LC3B_ARB_RR_EN: alternate on contention; otherwise D priority with a bounded D streak.
module mem_arbiter_pick
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic                i_req,
  input  logic                d_req,
  input  logic [STREAK_W-1:0] d_streak,
  input  lc3b_arb_src         last_grant,
  output logic                grant_valid,
  output lc3b_arb_src         grant_src
);

  always_comb begin
    grant_valid = i_req | d_req;
    grant_src   = d_req ? ARB_SRC_D : ARB_SRC_I;
    if (i_req && d_req) begin
`ifdef LC3B_ARB_RR_EN
      grant_src = (last_grant == ARB_SRC_D) ? ARB_SRC_I : ARB_SRC_D;
`else
      grant_src = (d_streak == STREAK_W'(MAX_D_STREAK)) ? ARB_SRC_I : ARB_SRC_D;
`endif
    end
  end

`ifdef LC3B_ARB_RR_EN
  logic unused_streak;
  assign unused_streak = ^d_streak;
`else
  logic unused_last_grant;
  assign unused_last_grant = (last_grant == ARB_SRC_D);
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one physical-memory port between the fetch (I) and load/store (D) clients.
// Build option LC3B_ARB_RR_EN switches contention handling to strict alternation.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int LINE_WIDTH   = 128,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_mem_read,
  input  logic [ADDR_WIDTH-1:0] i_mem_address,
  output logic [LINE_WIDTH-1:0] i_mem_rdata,
  output logic                  i_mem_resp,
  input  logic                  d_mem_read,
  input  logic                  d_mem_write,
  input  logic [ADDR_WIDTH-1:0] d_mem_address,
  input  logic [LINE_WIDTH-1:0] d_mem_wdata,
  output logic [LINE_WIDTH-1:0] d_mem_rdata,
  output logic                  d_mem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  lc3b_arb_state       state, state_next;
  logic [STREAK_W-1:0] d_streak;
  lc3b_arb_src         last_grant;
  logic                lat_write;
  logic                i_req, d_req;
  logic                grant_valid;
  lc3b_arb_src         grant_src;
  logic                take;
  logic                busy;

  assign i_req = i_mem_read;
  assign d_req = d_mem_read | d_mem_write;

  mem_arbiter_pick #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .d_streak   (d_streak),
    .last_grant (last_grant),
    .grant_valid(grant_valid),
    .grant_src  (grant_src)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE:
        if (grant_valid) state_next = (grant_src == ARB_SRC_D) ? ARB_BUSY_D : ARB_BUSY_I;
      ARB_BUSY_I, ARB_BUSY_D:
        if (pmem_resp) state_next = ARB_RELEASE;
      ARB_RELEASE:
        state_next = ARB_IDLE;
      default:
        state_next = ARB_IDLE;
    endcase
  end

  assign take = (state == ARB_IDLE) && grant_valid;

  // Everything the transaction needs is captured at grant so clients may drop mid-flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pmem_address <= '0;
      pmem_wdata   <= '0;
      lat_write    <= 1'b0;
      last_grant   <= ARB_SRC_I;
      d_streak     <= '0;
    end else if (take) begin
      last_grant <= grant_src;
      if (grant_src == ARB_SRC_D) begin
        pmem_address <= d_mem_address;
        pmem_wdata   <= d_mem_wdata;
        lat_write    <= d_mem_write;
      end else begin
        pmem_address <= i_mem_address;
        pmem_wdata   <= '0;
        lat_write    <= 1'b0;
      end
`ifdef LC3B_ARB_RR_EN
      d_streak <= '0;
`else
      d_streak <= streak_next(d_streak, grant_src == ARB_SRC_D, i_req, STREAK_W'(MAX_D_STREAK));
`endif
    end
  end

  assign busy       = (state == ARB_BUSY_I) || (state == ARB_BUSY_D);
  assign pmem_read  = busy & ~lat_write;
  assign pmem_write = busy & lat_write;

  assign i_mem_resp  = (state == ARB_BUSY_I) & pmem_resp;
  assign d_mem_resp  = (state == ARB_BUSY_D) & pmem_resp;
  assign i_mem_rdata = (state == ARB_BUSY_I) ? pmem_rdata : '0;
  assign d_mem_rdata = (state == ARB_BUSY_D) ? pmem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: transaction-level arbiter model feeding a scoreboard.
// Honours LC3B_ARB_RR_EN in the reference model so either build can be checked.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int AW   = 16;
  localparam int LW   = 128;
  localparam int MAXS = 4;
  localparam int TW   = 2 + AW + LW;
  localparam int RW   = 1 + LW;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_mem_read;
  logic [AW-1:0] i_mem_address;
  logic [LW-1:0] i_mem_rdata;
  logic          i_mem_resp;
  logic          d_mem_read;
  logic          d_mem_write;
  logic [AW-1:0] d_mem_address;
  logic [LW-1:0] d_mem_wdata;
  logic [LW-1:0] d_mem_rdata;
  logic          d_mem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  mem_arbiter #(
    .ADDR_WIDTH  (AW),
    .LINE_WIDTH  (LW),
    .MAX_D_STREAK(MAXS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_mem_read   (i_mem_read),
    .i_mem_address(i_mem_address),
    .i_mem_rdata  (i_mem_rdata),
    .i_mem_resp   (i_mem_resp),
    .d_mem_read   (d_mem_read),
    .d_mem_write  (d_mem_write),
    .d_mem_address(d_mem_address),
    .d_mem_wdata  (d_mem_wdata),
    .d_mem_rdata  (d_mem_rdata),
    .d_mem_resp   (d_mem_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [TW-1:0] exp_q[$];
  logic [RW-1:0] rsp_q[$];
  int errors = 0;
  int checks = 0;

  // Transaction-level view of the shared port: free, serving, or cooling down one cycle.
  typedef enum int {M_FREE, M_BUSY, M_COOL} m_phase_t;
  m_phase_t m_phase = M_FREE;
  logic     m_src_d = 1'b0;
  logic     m_last_d = 1'b0;
  int       m_d_run = 0;

  logic [TW-1:0] cur_txn = '0;
  logic          prev_strobe = 1'b0;
  logic          s_i_resp = 1'b0;
  logic          s_d_resp = 1'b0;
  logic          final_chk = 1'b0;
  logic          final_done = 1'b0;
  logic          to_flag = 1'b0;

  // stimulus controls
  logic          cli_en = 1'b0;
  logic          mem_en = 1'b1;
  logic          drop_en = 1'b0;
  int            req_pct = 0;
  int            fixed_lat = -1;
  logic [LW-1:0] fixed_data = '0;
  int            mem_wait = -1;

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // ---------------- monitor + reference model ----------------
  always @(negedge clk) begin
    logic [TW-1:0] act;
    logic [RW-1:0] act_r;
    logic          strobe;
    logic          i_p, d_p, g_d;
    s_i_resp = i_mem_resp;
    s_d_resp = d_mem_resp;
    if (rst) begin
      check("rst_strobes", TW'({pmem_read, pmem_write}), TW'(0));
      check("rst_resps", TW'({i_mem_resp, d_mem_resp}), TW'(0));
      check("rst_addr", TW'(pmem_address), TW'(0));
      check("rst_wdata", TW'(pmem_wdata), TW'(0));
      exp_q.delete();
      rsp_q.delete();
      m_phase     = M_FREE;
      m_d_run     = 0;
      m_last_d    = 1'b0;
      prev_strobe = 1'b0;
    end else begin
      if (m_phase == M_BUSY && pmem_resp) rsp_q.push_back({m_src_d, pmem_rdata});

      strobe = pmem_read | pmem_write;
      check("strobe_excl", TW'(pmem_read & pmem_write), TW'(0));
      check("strobe_timing", TW'(strobe), TW'(m_phase == M_BUSY));
      if (strobe) begin
        act = {pmem_write, pmem_read, pmem_address, (pmem_write ? pmem_wdata : {LW{1'b0}})};
        if (!prev_strobe) begin
          if (exp_q.size() == 0) fail_now("grant_unexpected");
          else begin
            cur_txn = exp_q.pop_front();
            check("grant", act, cur_txn);
          end
        end else begin
          check("hold", act, cur_txn);
        end
      end
      prev_strobe = strobe;

      check("resp_excl", TW'(i_mem_resp & d_mem_resp), TW'(0));
      if (i_mem_resp || d_mem_resp) begin
        act_r = {d_mem_resp, (d_mem_resp ? d_mem_rdata : i_mem_rdata)};
        if (rsp_q.size() == 0) fail_now("resp_unexpected");
        else check("resp", TW'(act_r), TW'(rsp_q.pop_front()));
      end
      if (rsp_q.size() != 0) begin
        check("resp_missing", TW'(0), TW'(rsp_q.size()));
        rsp_q.delete();
      end

      case (m_phase)
        M_FREE: begin
          i_p = i_mem_read;
          d_p = d_mem_read | d_mem_write;
          if (i_p || d_p) begin
            if (i_p && d_p) begin
`ifdef LC3B_ARB_RR_EN
              g_d = !m_last_d;
`else
              g_d = (m_d_run < MAXS);
`endif
            end else begin
              g_d = d_p;
            end
            if (!g_d) m_d_run = 0;
            else if (i_p && m_d_run < MAXS) m_d_run++;
            m_last_d = g_d;
            m_src_d  = g_d;
            if (g_d)
              exp_q.push_back({d_mem_write, !d_mem_write, d_mem_address,
                               (d_mem_write ? d_mem_wdata : {LW{1'b0}})});
            else
              exp_q.push_back({1'b0, 1'b1, i_mem_address, {LW{1'b0}}});
            m_phase = M_BUSY;
          end
        end
        M_BUSY: if (pmem_resp) m_phase = M_COOL;
        default: m_phase = M_FREE;
      endcase

      if (final_chk && !final_done) begin
        check("queue_drained", TW'(exp_q.size()), TW'(0));
        check("no_timeout", TW'(to_flag), TW'(0));
        final_done = 1'b1;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    if (pmem_resp) begin
      pmem_resp = 1'b0;
      mem_wait  = -1;
    end else if (mem_en) begin
      if (pmem_read | pmem_write) begin
        if (mem_wait < 0) mem_wait = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
        if (mem_wait == 0) begin
          pmem_resp  = 1'b1;
          pmem_rdata = (fixed_lat >= 0) ? fixed_data : rand_line();
          mem_wait   = -1;
        end else begin
          mem_wait--;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        pmem_resp  = 1'b1;
        pmem_rdata = rand_line();
      end
    end
    if (cli_en) begin
      if (i_mem_read) begin
        if (s_i_resp || (drop_en && m_phase == M_BUSY && !m_src_d && $urandom_range(0, 5) == 0))
          i_mem_read = 1'b0;
      end else if (!s_i_resp && int'($urandom_range(0, 99)) < req_pct) begin
        i_mem_read    = 1'b1;
        i_mem_address = AW'($urandom_range(0, 16'h7fff)) & 16'hfffe;
      end
      if (d_mem_read || d_mem_write) begin
        if (s_d_resp || (drop_en && m_phase == M_BUSY && m_src_d && $urandom_range(0, 5) == 0)) begin
          d_mem_read  = 1'b0;
          d_mem_write = 1'b0;
        end
      end else if (!s_d_resp && int'($urandom_range(0, 99)) < req_pct) begin
        case ($urandom_range(0, 2))
          0:       begin d_mem_read = 1'b1; d_mem_write = 1'b0; end
          1:       begin d_mem_read = 1'b0; d_mem_write = 1'b1; end
          default: begin d_mem_read = 1'b1; d_mem_write = 1'b1; end
        endcase
        d_mem_address = AW'($urandom_range(16'h8000, 16'hffff)) & 16'hfffe;
        d_mem_wdata   = rand_line();
      end
    end
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      step();
    end
  endtask

  initial begin
    rst           = 1'b1;
    i_mem_read    = 1'b0;
    i_mem_address = '0;
    d_mem_read    = 1'b0;
    d_mem_write   = 1'b0;
    d_mem_address = '0;
    d_mem_wdata   = '0;
    pmem_rdata    = '0;
    pmem_resp     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // lone fetch with a fixed three-cycle memory
    fixed_lat     = 3;
    fixed_data    = {16'hdead, 96'h0123_4567_89ab_cdef_0f1e_2d3c, 16'hbeef};
    i_mem_read    = 1'b1;
    i_mem_address = 16'h0040;
    begin
      bit got;
      got = 1'b0;
      for (int k = 0; k < 30 && !got; k++) begin
        @(posedge clk);
        #1;
        step();
        if (s_i_resp) begin
          i_mem_read = 1'b0;
          got        = 1'b1;
        end
      end
      if (!got) to_flag = 1'b1;
    end
    fixed_lat = -1;
    run_cycles(3);

    // light random traffic with mid-flight drops
    cli_en  = 1'b1;
    drop_en = 1'b1;
    req_pct = 30;
    run_cycles(1500);

    // saturated contention exposes the streak / alternation order
    drop_en = 1'b0;
    req_pct = 100;
    run_cycles(600);

    // drain outstanding requests
    req_pct = 0;
    begin
      bit idle;
      idle = 1'b0;
      for (int k = 0; k < 200 && !idle; k++) begin
        run_cycles(1);
        idle = !i_mem_read && !d_mem_read && !d_mem_write && (m_phase == M_FREE);
      end
      if (!idle) to_flag = 1'b1;
    end
    cli_en = 1'b0;
    run_cycles(2);

    // read+write together, then reset while the write is in flight
    mem_en        = 1'b0;
    d_mem_read    = 1'b1;
    d_mem_write   = 1'b1;
    d_mem_address = 16'h0100;
    d_mem_wdata   = {16{8'h11}};
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        run_cycles(1);
        seen = pmem_write;
      end
      if (!seen) to_flag = 1'b1;
    end
    @(posedge clk);
    #2;
    rst       = 1'b1;
    pmem_resp = 1'b1;
    @(posedge clk);
    #1;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    pmem_resp   = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    mem_en = 1'b1;
    run_cycles(8);

    final_chk = 1'b1;
    run_cycles(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
